// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder with programmable wait
// states, little-endian byte/half/word lanes and sign-extended loads.
// Optional macro DMEM_ERR_EN enables rejection of misaligned, out-of-range
// and conflicting accesses; without it, accesses are aligned down and wrapped.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic [1:0]  MemWrite,
  input  logic [1:0]  MemRead,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Ready,
  output logic        Busy,
  output logic        Error
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;

  stateT       state, nextState;
  logic [3:0]  cnt;
  logic [31:0] addrQ, wdataQ;
  logic [1:0]  wrQ, rdQ;
  logic        errQ;

  logic [31:0] mem [DEPTH_WORDS];

  logic          accept, enterResp;
  logic [31:0]   opAddr, opData;
  logic [1:0]    opWr, opRd, size;
  logic          isStore, isLoad, accErr;
  logic [AW-1:0] idx;
  logic [3:0]    be;
  logic [31:0]   wLane, rWord, rShift, loadVal;
  logic          unusedAddr;

  assign accept    = (state == IDLE) && Req && ((MemWrite != 2'b00) || (MemRead != 2'b00));
  assign enterResp = (nextState == RESP) && (state != RESP);

  // With zero wait states the access resolves on the acceptance edge, so the
  // live inputs are used in IDLE and the latched copies afterwards.
  always_comb begin
    opAddr  = (state == IDLE) ? Address   : addrQ;
    opData  = (state == IDLE) ? WriteData : wdataQ;
    opWr    = (state == IDLE) ? MemWrite  : wrQ;
    opRd    = (state == IDLE) ? MemRead   : rdQ;
    isStore = (opWr != 2'b00);
    isLoad  = (opRd != 2'b00) && !isStore;
    size    = isStore ? opWr : opRd;
    idx     = opAddr[AW+1:2];
  end

  assign unusedAddr = ^opAddr[31:AW+2];

  // Access legality.
  always_comb begin
`ifdef DMEM_ERR_EN
    accErr = ((size == 2'b01) && (opAddr[1:0] != 2'b00)) ||
             ((size == 2'b10) && opAddr[0]) ||
             ({2'b00, opAddr[31:2]} >= 32'(DEPTH_WORDS)) ||
             ((opWr != 2'b00) && (opRd != 2'b00));
`else
    accErr = 1'b0;
`endif
  end

  // Byte enables, replicated store lanes and sign-extended load extraction.
  always_comb begin
    be      = 4'b0000;
    wLane   = 32'h0;
    rWord   = mem[idx];
    rShift  = 32'h0;
    loadVal = 32'h0;
    case (size)
      2'b01: begin
        be      = 4'b1111;
        wLane   = opData;
        loadVal = rWord;
      end
      2'b10: begin
        be      = opAddr[1] ? 4'b1100 : 4'b0011;
        wLane   = {2{opData[15:0]}};
        rShift  = rWord >> {opAddr[1], 4'b0000};
        loadVal = {{16{rShift[15]}}, rShift[15:0]};
      end
      2'b11: begin
        be      = 4'b0001 << opAddr[1:0];
        wLane   = {4{opData[7:0]}};
        rShift  = rWord >> {opAddr[1:0], 3'b000};
        loadVal = {{24{rShift[7]}}, rShift[7:0]};
      end
      default: ;
    endcase
  end

  // FSM state register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= nextState;
  end

  // Next-state logic.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (accept) nextState = (WAIT_STATES == 0) ? RESP : WAIT;
      WAIT:    if (cnt == 4'd1) nextState = RESP;
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Request latches, wait counter, load result and error flag.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt      <= 4'd0;
      addrQ    <= 32'h0;
      wdataQ   <= 32'h0;
      wrQ      <= 2'b00;
      rdQ      <= 2'b00;
      errQ     <= 1'b0;
      ReadData <= 32'h0;
    end else begin
      if (accept) begin
        cnt    <= 4'(WAIT_STATES);
        addrQ  <= Address;
        wdataQ <= WriteData;
        wrQ    <= MemWrite;
        rdQ    <= MemRead;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (enterResp) begin
        errQ <= accErr;
        if (isLoad && !accErr) ReadData <= loadVal;
      end
    end
  end

  // Array write on the RESP-entry edge; gated by reset so an aborted
  // access never commits.
  always_ff @(posedge Clk) begin
    if (Reset && enterResp && isStore && !accErr) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wLane[8*b +: 8];
    end
  end

  assign Ready = (state == RESP);
  assign Busy  = (state != IDLE);
  assign Error = (state == RESP) && errQ;
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder (WAIT_STATES=2 main instance plus a
// WAIT_STATES=0 instance for the zero-latency path).
module tb_dmem_responder;
  logic        Clk = 1'b0, Reset = 1'b0;
  logic        Req = 1'b0;
  logic [1:0]  MemWrite = 2'b00, MemRead = 2'b00;
  logic [31:0] Address = 32'h0, WriteData = 32'h0;
  logic [31:0] ReadData;
  logic        Ready, Busy, Error;

  logic        zReq = 1'b0;
  logic [1:0]  zMemWrite = 2'b00, zMemRead = 2'b00;
  logic [31:0] zAddress = 32'h0, zWriteData = 32'h0;
  logic [31:0] zReadData;
  logic        zReady, zBusy, zError;

  int nChecks = 0, nErrors = 0;
  logic [31:0] lastRd = 32'h0;
  logic [31:0] expRdQ[$];
  logic        expErrQ[$];
  string       expNmQ[$];

  always #5 Clk = ~Clk;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .MemWrite(MemWrite), .MemRead(MemRead),
    .Address(Address), .WriteData(WriteData), .ReadData(ReadData),
    .Ready(Ready), .Busy(Busy), .Error(Error));

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut0 (
    .Clk(Clk), .Reset(Reset), .Req(zReq), .MemWrite(zMemWrite), .MemRead(zMemRead),
    .Address(zAddress), .WriteData(zWriteData), .ReadData(zReadData),
    .Ready(zReady), .Busy(zBusy), .Error(zError));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every Ready pulse is matched against the oldest expectation.
  always @(negedge Clk) begin
    if (Ready === 1'b1) begin
      if (expRdQ.size() == 0) begin
        nChecks++; nErrors++;
        $display("FAIL unexpected_ready: got Ready=1 expected no response");
      end else begin
        automatic logic [31:0] er = expRdQ.pop_front();
        automatic logic        ee = expErrQ.pop_front();
        automatic string       en = expNmQ.pop_front();
        chk({en, "_data"}, ReadData, er);
        chk({en, "_err"}, {31'h0, Error}, {31'h0, ee});
      end
    end
  end

  function automatic void pushExp(input logic [1:0] wr, input logic [1:0] rd,
                                  input logic [31:0] exp, input bit expErr, input string nm);
    if (rd != 2'b00 && wr == 2'b00 && !expErr) lastRd = exp;
    expRdQ.push_back(lastRd);
    expErrQ.push_back(expErr);
    expNmQ.push_back(nm);
  endfunction

  // One access on the main instance: checks Busy/Ready timing, then
  // scrambles the inputs to prove they were latched.
  task automatic doAccess(input logic [1:0] wr, input logic [1:0] rd, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp, input bit expErr,
                          input string nm);
    @(negedge Clk);
    Req = 1'b1; MemWrite = wr; MemRead = rd; Address = addr; WriteData = wd;
    @(posedge Clk);
    pushExp(wr, rd, exp, expErr, nm);
    #1;
    Req = 1'b0; Address = 32'hFFFF_FFFC; WriteData = ~wd;
    for (int c = 1; c <= 3; c++) begin
      @(negedge Clk);
      chk({nm, "_busy"}, {31'h0, Busy}, 32'h1);
      chk({nm, "_ready"}, {31'h0, Ready}, (c == 3) ? 32'h1 : 32'h0);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit errEn;
`ifdef DMEM_ERR_EN
    errEn = 1'b1;
`else
    errEn = 1'b0;
`endif
    repeat (3) @(negedge Clk);
    chk("rst_readdata", ReadData, 32'h0);
    chk("rst_ready", {31'h0, Ready}, 32'h0);
    chk("rst_busy", {31'h0, Busy}, 32'h0);
    chk("rst_error", {31'h0, Error}, 32'h0);
    Reset = 1'b1;

    // Zero-wait-state instance: Ready in cycle 1.
    @(negedge Clk);
    zReq = 1'b1; zMemWrite = 2'b01; zAddress = 32'h8; zWriteData = 32'hA5A5_A5A5;
    @(posedge Clk); #1 zReq = 1'b0; zMemWrite = 2'b00;
    @(negedge Clk);
    chk("ws0_sw_ready", {31'h0, zReady}, 32'h1);
    chk("ws0_sw_busy", {31'h0, zBusy}, 32'h1);
    @(negedge Clk);
    chk("ws0_sw_ready_off", {31'h0, zReady}, 32'h0);
    zReq = 1'b1; zMemRead = 2'b01; zAddress = 32'h8;
    @(posedge Clk); #1 zReq = 1'b0; zMemRead = 2'b00;
    @(negedge Clk);
    chk("ws0_lw_ready", {31'h0, zReady}, 32'h1);
    chk("ws0_lw_data", zReadData, 32'hA5A5_A5A5);
    chk("ws0_lw_err", {31'h0, zError}, 32'h0);

    // Word store/load.
    doAccess(2'b01, 2'b00, 32'h10, 32'hDEAD_BEEF, 32'h0, 0, "sw10");
    doAccess(2'b00, 2'b01, 32'h10, 32'h0, 32'hDEAD_BEEF, 0, "lw10");

    // Lane selection and sign extension.
    doAccess(2'b01, 2'b00, 32'h20, 32'h80FF_7F01, 32'h0, 0, "sw20");
    doAccess(2'b00, 2'b11, 32'h21, 32'h0, 32'h0000_007F, 0, "lb21");
    doAccess(2'b00, 2'b11, 32'h22, 32'h0, 32'hFFFF_FFFF, 0, "lb22");
    doAccess(2'b00, 2'b10, 32'h22, 32'h0, 32'hFFFF_80FF, 0, "lh22");
    doAccess(2'b11, 2'b00, 32'h23, 32'h0000_00AA, 32'h0, 0, "sb23");
    doAccess(2'b00, 2'b01, 32'h20, 32'h0, 32'hAAFF_7F01, 0, "lw20");
    doAccess(2'b10, 2'b00, 32'h22, 32'h0000_1234, 32'h0, 0, "sh22");
    doAccess(2'b00, 2'b01, 32'h20, 32'h0, 32'h1234_7F01, 0, "lw20b");

    // Misaligned word access.
    doAccess(2'b00, 2'b01, 32'h12, 32'h0, 32'hDEAD_BEEF, errEn, "lw12");
    doAccess(2'b01, 2'b00, 32'h12, 32'h1234_5678, 32'h0, errEn, "sw12");
    doAccess(2'b00, 2'b01, 32'h10, 32'h0, errEn ? 32'hDEAD_BEEF : 32'h1234_5678, 0, "lw10b");

    // Out-of-range store.
    doAccess(2'b01, 2'b00, 32'h0, 32'h1111_1111, 32'h0, 0, "sw00");
    doAccess(2'b01, 2'b00, 32'h1000, 32'hCAFE_F00D, 32'h0, errEn, "sw1000");
    doAccess(2'b00, 2'b01, 32'h0, 32'h0, errEn ? 32'h1111_1111 : 32'hCAFE_F00D, 0, "lw00");

    // Store and load requested together.
    doAccess(2'b01, 2'b00, 32'h30, 32'h0102_0304, 32'h0, 0, "sw30");
    doAccess(2'b01, 2'b01, 32'h30, 32'h55AA_55AA, 32'h0, errEn, "swlw30");
    doAccess(2'b00, 2'b01, 32'h30, 32'h0, errEn ? 32'h0102_0304 : 32'h55AA_55AA, 0, "lw30");

    // Req held high, command alternating every cycle; only IDLE edges accept.
    for (int i = 0; i < 16; i++) begin
      @(negedge Clk);
      if (i > 0) begin
        chk($sformatf("hold_busy%0d", i), {31'h0, Busy}, (i % 4 != 0) ? 32'h1 : 32'h0);
        chk($sformatf("hold_ready%0d", i), {31'h0, Ready}, (i % 4 == 3) ? 32'h1 : 32'h0);
      end
      Req = 1'b1; Address = 32'h50;
      if (((i + i / 4) % 2) == 0) begin
        MemWrite = 2'b01; MemRead = 2'b00; WriteData = 32'h300 + 32'(i);
      end else begin
        MemWrite = 2'b00; MemRead = 2'b01; WriteData = 32'h0;
      end
      @(posedge Clk);
      if (i % 4 == 0)
        pushExp(MemWrite, MemRead, 32'h300 + 32'(i - 4), 0, $sformatf("hold%0d", i));
    end
    #1 Req = 1'b0; MemWrite = 2'b00; MemRead = 2'b00;

    // Reset during a store aborts it.
    doAccess(2'b01, 2'b00, 32'h40, 32'h1234_5678, 32'h0, 0, "sw40");
    @(negedge Clk);
    Req = 1'b1; MemWrite = 2'b01; Address = 32'h40; WriteData = 32'h55;
    @(posedge Clk); #1 Req = 1'b0; MemWrite = 2'b00; Reset = 1'b0;
    #1;
    chk("abort_busy", {31'h0, Busy}, 32'h0);
    chk("abort_ready", {31'h0, Ready}, 32'h0);
    chk("abort_readdata", ReadData, 32'h0);
    repeat (3) @(negedge Clk);
    Reset = 1'b1; lastRd = 32'h0;
    repeat (4) @(negedge Clk);
    doAccess(2'b00, 2'b01, 32'h40, 32'h0, 32'h1234_5678, 0, "lw40");

    for (int k = 0; k < 20 && expRdQ.size() != 0; k++) @(negedge Clk);
    chk("drain_queue", 32'(expRdQ.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end
endmodule
